// File: rtl/washer_pkg.sv
// Shared definitions for the washer sequencer: state codes, program (mode)
// codes, phase_sel display codes and the rinse-count clamp helper.
package washer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_READY = 4'd1,
      ST_SOAK  = 4'd2,
      ST_WASH  = 4'd3,
      ST_RINSE = 4'd4,
      ST_SPIN  = 4'd5,
      ST_PAUSE = 4'd6,
      ST_DONE  = 4'd7
   } state_t;

   typedef enum logic [1:0] {
      MODE_NORMAL    = 2'd0,
      MODE_QUICK     = 2'd1,
      MODE_HEAVY     = 2'd2,
      MODE_SPIN_ONLY = 2'd3
   } mode_t;

   localparam logic [1:0] PSEL_SOAK  = 2'b00;
   localparam logic [1:0] PSEL_WASH  = 2'b01;
   localparam logic [1:0] PSEL_RINSE = 2'b10;
   localparam logic [1:0] PSEL_SPIN  = 2'b11;

   // Requested rinse passes forced into 1..max_r; a request of 0 still rinses once.
   function automatic int unsigned clamp_rinse(input int unsigned req, input int unsigned max_r);
      int unsigned r;
      if (req == 0)
         r = 1;
      else if (req > max_r)
         r = max_r;
      else
         r = req;
      return r;
   endfunction

endpackage

// File: rtl/washer_phase_timer.sv
// Phase down-counter for the washer sequencer.
// Ports:
//   clk, rst_n   clock, async active-low reset (count -> 0)
//   en           global enable; when low the counter holds regardless of load
//   load         load load_val (takes priority over hold)
//   load_val     value loaded on load
//   hold         freeze the count (pause, idle states)
//   count        current value
//   zero         count == 0
module washer_phase_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             hold,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         if (load)
            count <= load_val;
         else if (!hold && count != '0)
            count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/washer_seq_ctrl.sv
// Washing-machine sequencer: program selection, per-phase internal timers,
// rinse pass counting and lid-open pause/resume.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   power_on       global enable; all registers hold when low
//   start          level, starts a program from IDLE / resumes from PAUSE
//   cancel         abort to IDLE from any state
//   lid            1 = lid open
//   mode           program: NORMAL, QUICK, HEAVY, SPIN_ONLY
//   rinse_n        requested rinse passes (clamped to 1..MAX_RINSE)
//   state          current state code
//   phase_sel      display phase code
//   *_en           one-hot phase enables to the motor/valve drivers
//   timer_active   a phase is running
//   remain         phase timer value (also shown while paused)
//   rinse_left     rinse passes still to run, including the current one
//   busy, done     state != IDLE, state == DONE
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start with lid closed
// READY    | program latched; next enabled cycle enters the first phase
// SOAK     | soak phase, SOAK_T cycles
// WASH     | wash phase, WASH_T cycles (2*WASH_T in HEAVY)
// RINSE    | one rinse pass of RINSE_T cycles, repeated rinse_left times
// SPIN     | spin phase, SPIN_T cycles
// PAUSE    | lid opened mid-phase; timer held, resumes saved phase on start
// DONE     | one-cycle completion marker
module washer_seq_ctrl
   import washer_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int SOAK_T    = 600,
   parameter int WASH_T    = 1200,
   parameter int RINSE_T   = 400,
   parameter int SPIN_T    = 300,
   parameter int MAX_RINSE = 3,
   parameter int RC_W      = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             power_on,
   input  logic             start,
   input  logic             cancel,
   input  logic             lid,
   input  logic [1:0]       mode,
   input  logic [RC_W-1:0]  rinse_n,
   output logic [3:0]       state,
   output logic [1:0]       phase_sel,
   output logic             soak_en,
   output logic             wash_en,
   output logic             rinse_en,
   output logic             spin_en,
   output logic             timer_active,
   output logic [CNT_W-1:0] remain,
   output logic [RC_W-1:0]  rinse_left,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] SOAK_LD  = CNT_W'(SOAK_T - 1);
   localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_T - 1);
   localparam logic [CNT_W-1:0] WASHH_LD = CNT_W'(2 * WASH_T - 1);
   localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_T - 1);
   localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_T - 1);
   localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);

   state_t           state_q, state_d;
   state_t           saved_q, saved_d;
   mode_t            mode_q, mode_d;
   logic [RC_W-1:0]  rinse_q, rinse_d;

   logic             tmr_load, tmr_hold, tmr_zero;
   logic [CNT_W-1:0] tmr_val, tmr_count;

   washer_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (power_on),
      .load     (tmr_load),
      .load_val (tmr_val),
      .hold     (tmr_hold),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         saved_q <= ST_IDLE;
         mode_q  <= MODE_NORMAL;
         rinse_q <= '0;
      end else if (power_on) begin
         state_q <= state_d;
         saved_q <= saved_d;
         mode_q  <= mode_d;
         rinse_q <= rinse_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      saved_d  = saved_q;
      mode_d   = mode_q;
      rinse_d  = rinse_q;
      tmr_load = 1'b0;
      tmr_hold = 1'b1;
      tmr_val  = '0;
      if (cancel && state_q != ST_IDLE) begin
         // Loading zero clears the timer so the display blanks cleanly.
         state_d  = ST_IDLE;
         rinse_d  = '0;
         tmr_load = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !lid && !cancel) begin
                  state_d = ST_READY;
                  mode_d  = mode_t'(mode);
                  rinse_d = RC_W'(clamp_rinse(32'(rinse_n), MAX_RINSE));
               end
            end
            ST_READY: begin
               if (!lid) begin
                  tmr_load = 1'b1;
                  case (mode_q)
                     MODE_QUICK: begin
                        state_d = ST_WASH;
                        tmr_val = WASH_LD;
                     end
                     MODE_SPIN_ONLY: begin
                        // No rinse will run in this program.
                        state_d = ST_SPIN;
                        tmr_val = SPIN_LD;
                        rinse_d = '0;
                     end
                     default: begin
                        state_d = ST_SOAK;
                        tmr_val = SOAK_LD;
                     end
                  endcase
               end
            end
            ST_SOAK, ST_WASH, ST_RINSE, ST_SPIN: begin
               if (lid) begin
                  state_d = ST_PAUSE;
                  saved_d = state_q;
               end else if (tmr_zero) begin
                  case (state_q)
                     ST_SOAK: begin
                        state_d  = ST_WASH;
                        tmr_load = 1'b1;
                        tmr_val  = (mode_q == MODE_HEAVY) ? WASHH_LD : WASH_LD;
                     end
                     ST_WASH: begin
                        state_d  = ST_RINSE;
                        tmr_load = 1'b1;
                        tmr_val  = RINSE_LD;
                     end
                     ST_RINSE: begin
                        tmr_load = 1'b1;
                        if (rinse_q > RC_ONE) begin
                           rinse_d = rinse_q - RC_ONE;
                           tmr_val = RINSE_LD;
                        end else begin
                           state_d = ST_SPIN;
                           rinse_d = '0;
                           tmr_val = SPIN_LD;
                        end
                     end
                     default: state_d = ST_DONE;
                  endcase
               end else begin
                  tmr_hold = 1'b0;
               end
            end
            ST_PAUSE: begin
               if (!lid && start)
                  state_d = saved_q;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      phase_sel = PSEL_SOAK;
      soak_en   = 1'b0;
      wash_en   = 1'b0;
      rinse_en  = 1'b0;
      spin_en   = 1'b0;
      remain    = '0;
      case (state_q)
         ST_SOAK: begin
            soak_en = 1'b1;
            remain  = tmr_count;
         end
         ST_WASH: begin
            wash_en   = 1'b1;
            phase_sel = PSEL_WASH;
            remain    = tmr_count;
         end
         ST_RINSE: begin
            rinse_en  = 1'b1;
            phase_sel = PSEL_RINSE;
            remain    = tmr_count;
         end
         ST_SPIN: begin
            spin_en   = 1'b1;
            phase_sel = PSEL_SPIN;
            remain    = tmr_count;
         end
         ST_PAUSE: remain = tmr_count;
         default: ;
      endcase
   end

   assign state        = state_q;
   assign timer_active = soak_en | wash_en | rinse_en | spin_en;
   assign rinse_left   = rinse_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_washer_seq_ctrl.sv
module tb_washer_seq_ctrl;
   import washer_pkg::*;

   localparam int CNT_W = 16, SOAK_T = 4, WASH_T = 6, RINSE_T = 3, SPIN_T = 5;
   localparam int MAX_RINSE = 3, RC_W = 3;

   logic clk, rst_n, power_on, start, cancel, lid;
   logic [1:0] mode;
   logic [RC_W-1:0] rinse_n;
   logic [3:0] state;
   logic [1:0] phase_sel;
   logic soak_en, wash_en, rinse_en, spin_en, timer_active, busy, done;
   logic [CNT_W-1:0] remain;
   logic [RC_W-1:0] rinse_left;

   int n_pass = 0, n_total = 0;

   washer_seq_ctrl #(.CNT_W(CNT_W), .SOAK_T(SOAK_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T),
                     .SPIN_T(SPIN_T), .MAX_RINSE(MAX_RINSE), .RC_W(RC_W)) dut (
      .clk(clk), .rst_n(rst_n), .power_on(power_on), .start(start), .cancel(cancel),
      .lid(lid), .mode(mode), .rinse_n(rinse_n), .state(state), .phase_sel(phase_sel),
      .soak_en(soak_en), .wash_en(wash_en), .rinse_en(rinse_en), .spin_en(spin_en),
      .timer_active(timer_active), .remain(remain), .rinse_left(rinse_left),
      .busy(busy), .done(done));

   wire [31:0] all_out = {state, phase_sel, soak_en, wash_en, rinse_en, spin_en,
                          timer_active, remain, rinse_left, busy, done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: expected per-enabled-cycle trace of a whole program run.
   typedef struct { logic [3:0] st; int rem; int rl; } rec_t;
   rec_t exp_q[$];

   function automatic void push_phase(input logic [3:0] st, input int dur, input int rl);
      for (int i = dur - 1; i >= 0; i--) exp_q.push_back('{st, i, rl});
   endfunction

   function automatic void build(input int md, input int rn);
      int rl;
      rl = (rn == 0) ? 1 : ((rn > MAX_RINSE) ? MAX_RINSE : rn);
      exp_q.delete();
      exp_q.push_back('{ST_READY, 0, rl});
      if (md == 0 || md == 2) push_phase(ST_SOAK, SOAK_T, rl);
      if (md != 3) begin
         push_phase(ST_WASH, (md == 2) ? 2 * WASH_T : WASH_T, rl);
         for (int p = 0; p < rl; p++) push_phase(ST_RINSE, RINSE_T, rl - p);
      end
      push_phase(ST_SPIN, SPIN_T, 0);
      exp_q.push_back('{ST_DONE, 0, 0});
   endfunction

   function automatic logic [31:0] exp_vec(input logic [3:0] st, input int rem, input int rl);
      logic [1:0] ps;
      logic [3:0] en;
      ps = 2'b00;
      en = 4'b0000;
      case (st)
         ST_SOAK:  en = 4'b1000;
         ST_WASH:  begin en = 4'b0100; ps = 2'b01; end
         ST_RINSE: begin en = 4'b0010; ps = 2'b10; end
         ST_SPIN:  begin en = 4'b0001; ps = 2'b11; end
         default: ;
      endcase
      return {st, ps, en, |en, 16'(rem), 3'(rl), st != ST_IDLE, st == ST_DONE};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input int md, input int rn);
      mode = 2'(md);
      rinse_n = 3'(rn);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic abort();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
   endtask

   task automatic wait_for(input logic [3:0] st, input int rem, input int budget, output bit ok);
      int n;
      n = 0;
      while (!(state == st && (rem < 0 || int'(remain) == rem)) && n < budget) begin
         step();
         n++;
      end
      ok = (state == st && (rem < 0 || int'(remain) == rem));
   endtask

   task automatic test_reset();
      #2;
      n_total++;
      if (all_out !== 32'h0) $display("FAIL reset_outputs: got %h expected %h", all_out, 32'h0);
      else n_pass++;
      rst_n = 1'b1;
      step();
      step();
      n_total++;
      if (all_out !== 32'h0) $display("FAIL idle_after_reset: got %h expected %h", all_out, 32'h0);
      else n_pass++;
   endtask

   task automatic test_normal();
      int t_done, c_soak, c_wash, c_r2, c_r1, c_spin, c_done;
      t_done = -1; c_soak = 0; c_wash = 0; c_r2 = 0; c_r1 = 0; c_spin = 0; c_done = 0;
      kick(0, 2);
      n_total++;
      if (state !== ST_READY) $display("FAIL normal_ready: got %0d expected %0d", state, ST_READY);
      else n_pass++;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         step();
         case (state)
            ST_SOAK:  c_soak++;
            ST_WASH:  c_wash++;
            ST_RINSE: if (rinse_left == 2) c_r2++; else if (rinse_left == 1) c_r1++;
            ST_SPIN:  c_spin++;
            ST_DONE:  begin c_done++; if (t_done < 0) t_done = cyc; end
            default: ;
         endcase
      end
      n_total++;
      if (t_done != 22) $display("FAIL normal_done_time: got %0d expected 22", t_done); else n_pass++;
      n_total++;
      if ({c_soak, c_wash, c_spin, c_done} != {32'd4, 32'd6, 32'd5, 32'd1})
         $display("FAIL normal_phase_lengths: got soak %0d wash %0d spin %0d done %0d expected 4 6 5 1",
                  c_soak, c_wash, c_spin, c_done);
      else n_pass++;
      n_total++;
      if (c_r2 != 3 || c_r1 != 3) $display("FAIL normal_rinse_passes: got %0d/%0d expected 3/3", c_r2, c_r1);
      else n_pass++;
      n_total++;
      if (all_out !== 32'h0) $display("FAIL normal_back_idle: got %h expected %h", all_out, 32'h0);
      else n_pass++;
   endtask

   task automatic test_heavy_quick();
      int c_wash, c_rinse, c_soak;
      c_wash = 0; c_rinse = 0;
      kick(2, 0);
      for (int i = 0; i < 40; i++) begin
         step();
         if (wash_en) c_wash++;
         if (rinse_en) c_rinse++;
      end
      n_total++;
      if (c_wash != 12 || c_rinse != RINSE_T)
         $display("FAIL heavy_lengths: got wash %0d rinse %0d expected 12 %0d", c_wash, c_rinse, RINSE_T);
      else n_pass++;
      c_wash = 0; c_soak = 0;
      kick(1, 1);
      for (int i = 0; i < 30; i++) begin
         step();
         if (wash_en) c_wash++;
         if (soak_en) c_soak++;
      end
      n_total++;
      if (c_soak != 0 || c_wash != WASH_T || state !== ST_IDLE)
         $display("FAIL quick_no_soak: got soak %0d wash %0d state %0d expected 0 %0d 0", c_soak, c_wash, state, WASH_T);
      else n_pass++;
   endtask

   task automatic test_pause();
      bit ok, bad;
      int n;
      kick(0, 1);
      wait_for(ST_WASH, 3, 40, ok);
      n_total++;
      if (!ok) $display("FAIL pause_reach_wash3: got state %0d remain %0d expected WASH 3", state, remain); else n_pass++;
      lid = 1'b1;
      step();
      n_total++;
      if (state !== ST_PAUSE || remain !== 16'd3 || wash_en !== 1'b0 || timer_active !== 1'b0)
         $display("FAIL pause_enter: got state %0d remain %0d wash_en %b expected %0d 3 0", state, remain, wash_en, ST_PAUSE);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         start = (i % 2 == 0);
         step();
         if (state !== ST_PAUSE || remain !== 16'd3 || wash_en !== 1'b0) bad = 1;
      end
      n_total++;
      if (bad) $display("FAIL pause_hold: got state %0d remain %0d expected %0d 3", state, remain, ST_PAUSE); else n_pass++;
      lid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      n_total++;
      if (state !== ST_WASH || remain !== 16'd3 || wash_en !== 1'b1)
         $display("FAIL pause_resume: got state %0d remain %0d expected %0d 3", state, remain, ST_WASH);
      else n_pass++;
      n = 0;
      while (state == ST_WASH && n < 20) begin n++; step(); end
      n_total++;
      if (n != 4 || state !== ST_RINSE || remain !== 16'(RINSE_T - 1))
         $display("FAIL pause_wash_tail: got %0d cycles state %0d expected 4 %0d", n, state, ST_RINSE);
      else n_pass++;
      abort();
   endtask

   task automatic test_cancel_rinse();
      bit ok, spin_seen;
      kick(0, 1);
      wait_for(ST_RINSE, 0, 40, ok);
      n_total++;
      if (!ok) $display("FAIL cancel_reach_rinse0: got state %0d remain %0d expected RINSE 0", state, remain); else n_pass++;
      abort();
      n_total++;
      if (all_out !== 32'h0) $display("FAIL cancel_to_idle: got %h expected %h", all_out, 32'h0); else n_pass++;
      spin_seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (spin_en || state !== ST_IDLE) spin_seen = 1;
      end
      n_total++;
      if (spin_seen) $display("FAIL cancel_no_spin: got spin/state activity expected none"); else n_pass++;
   endtask

   task automatic test_power_hold();
      bit ok, bad;
      kick(0, 1);
      wait_for(ST_SOAK, 2, 20, ok);
      n_total++;
      if (!ok) $display("FAIL power_reach_soak2: got state %0d remain %0d expected SOAK 2", state, remain); else n_pass++;
      power_on = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (state !== ST_SOAK || remain !== 16'd2) bad = 1;
      end
      n_total++;
      if (bad) $display("FAIL power_freeze: got state %0d remain %0d expected %0d 2", state, remain, ST_SOAK); else n_pass++;
      power_on = 1'b1;
      step();
      step();
      step();
      n_total++;
      if (state !== ST_WASH || remain !== 16'(WASH_T - 1))
         $display("FAIL power_continue: got state %0d remain %0d expected %0d %0d", state, remain, ST_WASH, WASH_T - 1);
      else n_pass++;
      abort();
   endtask

   task automatic test_rinse_sat();
      int passes, c_rinse;
      passes = 0; c_rinse = 0;
      kick(0, 7);
      n_total++;
      if (rinse_left !== 3'd3) $display("FAIL sat_latch: got %0d expected 3", rinse_left); else n_pass++;
      for (int i = 0; i < 40; i++) begin
         step();
         if (rinse_en) c_rinse++;
         if (rinse_en && remain == 16'(RINSE_T - 1)) passes++;
      end
      n_total++;
      if (passes != 3 || c_rinse != 3 * RINSE_T)
         $display("FAIL sat_passes: got %0d passes %0d cycles expected 3 %0d", passes, c_rinse, 3 * RINSE_T);
      else n_pass++;
   endtask

   task automatic test_random();
      rec_t cur;
      int guard, md, rn;
      bit pw;
      for (int r = 0; r < 12; r++) begin
         md = $urandom_range(0, 3);
         rn = $urandom_range(0, 7);
         build(md, rn);
         power_on = 1'b1;
         kick(md, rn);
         cur = exp_q.pop_front();
         n_total++;
         if (all_out !== exp_vec(cur.st, cur.rem, cur.rl))
            $display("FAIL random_ready run %0d: got %h expected %h", r, all_out, exp_vec(cur.st, cur.rem, cur.rl));
         else n_pass++;
         guard = 0;
         while (exp_q.size() > 0 && guard < 200) begin
            pw = ($urandom_range(0, 4) != 0);
            power_on = pw;
            step();
            guard++;
            if (pw) cur = exp_q.pop_front();
            n_total++;
            if (all_out !== exp_vec(cur.st, cur.rem, cur.rl))
               $display("FAIL random_trace run %0d mode %0d: got %h expected %h", r, md, all_out, exp_vec(cur.st, cur.rem, cur.rl));
            else n_pass++;
         end
         n_total++;
         if (guard >= 200) $display("FAIL random_timeout run %0d: got %0d cycles expected fewer", r, guard);
         else n_pass++;
         power_on = 1'b1;
         step();
         n_total++;
         if (all_out !== 32'h0) $display("FAIL random_idle run %0d: got %h expected %h", r, all_out, 32'h0);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      bit ok, bad;
      kick(0, 1);
      wait_for(ST_SPIN, -1, 40, ok);
      n_total++;
      if (!ok) $display("FAIL areset_reach_spin: got state %0d expected %0d", state, ST_SPIN); else n_pass++;
      #3;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (all_out !== 32'h0) $display("FAIL areset_immediate: got %h expected %h", all_out, 32'h0); else n_pass++;
      #3;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (all_out !== 32'h0) bad = 1;
      end
      n_total++;
      if (bad) $display("FAIL areset_needs_start: got %h expected %h", all_out, 32'h0); else n_pass++;
      kick(0, 1);
      n_total++;
      if (state !== ST_READY) $display("FAIL areset_restart: got %0d expected %0d", state, ST_READY); else n_pass++;
      abort();
   endtask

   initial begin
      rst_n = 1'b0; power_on = 1'b1; start = 1'b0; cancel = 1'b0; lid = 1'b0;
      mode = 2'd0; rinse_n = '0;
      test_reset();
      test_normal();
      test_heavy_quick();
      test_pause();
      test_cancel_rinse();
      test_power_hold();
      test_rinse_sat();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
